// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port of dmem_arbiter.
// The slave modport is the arbiter's view; the master modport is the environment.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_ack;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic [1:0]        fsm_state;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_rdata, m0_ack, m1_rdata, m1_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, fsm_state
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_rdata, m0_ack, m1_rdata, m1_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, fsm_state
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between the CPU load/store port (0)
// and the debug/loader port (1); one transaction at a time, fixed memory latency.
module dmem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  // Handshake: a requester raises mX_req with we/addr/wdata stable and holds them
  // until mX_ack pulses for one cycle; the arbiter only samples them while IDLE.
  // mem_rdata is sampled on the MEM_LATENCY-th rising edge after mem_en is raised,
  // the edge that closes the ISSUE cycle counting as the first.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));

  state_t            state;
  logic              last_grant;
  logic              grant;
  logic              xfer_we;
  logic [3:0]        lat_cnt;

  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              ack0_q;
  logic              ack1_q;

  logic              any_req;
  logic              win;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              data_ready;

  always_comb begin
    any_req    = bus.m0_req | bus.m1_req;
    // Port 1 wins when alone, or on a tie when port 0 was served last.
    win        = bus.m1_req & (~bus.m0_req | ~last_grant);
    win_we     = win ? bus.m1_we    : bus.m0_we;
    win_addr   = (win ? bus.m1_addr : bus.m0_addr) & WORD_MASK;
    win_wdata  = win ? bus.m1_wdata : bus.m0_wdata;
    data_ready = ((state == S_ISSUE) && (MEM_LATENCY == 1)) ||
                 ((state == S_WAIT) && (lat_cnt == 4'd1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      last_grant  <= 1'b1;
      grant       <= 1'b0;
      xfer_we     <= 1'b0;
      lat_cnt     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant       <= win;
            xfer_we     <= win_we;
            mem_en_q    <= 1'b1;
            mem_we_q    <= win_we;
            mem_addr_q  <= win_addr;
            mem_wdata_q <= win_wdata;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_en_q    <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          lat_cnt     <= LAT_LOAD;
          state       <= S_WAIT;
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
        end
        S_ACK: begin
          last_grant <= grant;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // With MEM_LATENCY=1 this fires out of ISSUE and overrides the WAIT transition.
      if (data_ready) begin
        state <= S_ACK;
        if (grant) begin
          ack1_q   <= 1'b1;
          rdata1_q <= xfer_we ? '0 : bus.mem_rdata;
        end else begin
          ack0_q   <= 1'b1;
          rdata0_q <= xfer_we ? '0 : bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.m0_ack    = ack0_q;
  assign bus.m1_ack    = ack1_q;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
  assign bus.busy      = (state != S_IDLE);
  assign bus.fsm_state = state;

endmodule
